// File: rtl/d_reg_pipe_if.sv
// Valid/ready bus for d_reg_pipe: upstream (in_*) and downstream (out_*) sides.
interface d_reg_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Pipe side: consumes in_*, produces out_*.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: produces in_*, consumes out_*.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/d_reg_pipe.sv
// Elastic register chain: DEPTH skid-buffered stages, full throughput, no
// combinational ready path between stages. Registered occupancy count.

// One skid stage: main entry feeds downstream, skid entry absorbs a word
// arriving while main is stalled. ready_up depends only on skid_v.
module d_reg_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_up,
  input  logic [WIDTH-1:0] din,
  output logic             ready_up,
  input  logic             ready_down,
  output logic             valid_dn,
  output logic [WIDTH-1:0] dout
);
  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_d, skid_d;
  logic             take_out, accept;

  assign take_out = main_v & ready_down;
  assign accept   = valid_up & ~skid_v;
  assign ready_up = ~skid_v;
  assign valid_dn = main_v;
  assign dout     = main_d;

  // Stage update in priority order; flush drops valid bits but keeps data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v && take_out) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
    end else if (accept && main_v && !take_out) begin
      skid_d <= din;
      skid_v <= 1'b1;
    end else if (accept) begin
      main_d <= din;
      main_v <= 1'b1;
    end else if (take_out) begin
      main_v <= 1'b0;
    end
  end
endmodule

module d_reg_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               OCC_W     = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  d_reg_pipe_if.slave      bus,
  output logic [OCC_W-1:0] occupancy
);
  // Link k is upstream of stage k; link DEPTH is the pipe output.
  logic [DEPTH:0]            vld;
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0][WIDTH-1:0] dat;
  logic                      live;
  logic                      in_xfer, out_xfer;

  // Reset and flush block both external handshakes this cycle.
  assign live          = rst & ~flush;
  assign vld[0]        = bus.in_valid & live;
  assign dat[0]        = bus.in_data;
  assign rdy[DEPTH]    = bus.out_ready & live;
  assign bus.in_ready  = rdy[0] & live;
  assign bus.out_valid = vld[DEPTH] & live;
  assign bus.out_data  = dat[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    d_reg_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .valid_up  (vld[k]),
      .din       (dat[k]),
      .ready_up  (rdy[k]),
      .ready_down(rdy[k+1]),
      .valid_dn  (vld[k+1]),
      .dout      (dat[k+1])
    );
  end

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // Internal moves conserve entries, so only boundary transfers change the count.
  always_ff @(posedge clk) begin
    if (!rst || flush) occupancy <= '0;
    else occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end
endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed + random bench for d_reg_pipe with an in-order scoreboard.
module tb_d_reg_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam logic [7:0] RV = 8'h3C;
  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic clk = 1'b0;
  logic rst, flush;
  logic [OCC_W-1:0] occupancy;
  d_reg_pipe_if #(.WIDTH(WIDTH)) b ();

  d_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(b), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample handshakes mid-cycle, score, then step past the edge.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic [7:0] e;
    b.in_valid  = iv;
    b.in_data   = id;
    b.out_ready = ordy;
    flush       = fl;
    @(negedge clk);
    if (b.out_valid && b.out_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_data", b.out_data, e);
      end
      n_pop++;
    end
    if (b.in_valid && b.in_ready) q.push_back(b.in_data);
    if (!rst || fl) q.delete();
    @(posedge clk);
    #1;
    chk("occ", occupancy, q.size());
  endtask

  initial begin
    int p0, v, acc;
    logic ok, rdy_all;
    rst = 1'b0; flush = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;

    // Reset with in_valid held high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("rst_in_ready", b.in_ready, 0);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_data", b.out_data, RV);
    chk("rst_occ", occupancy, 0);
    b.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", b.in_ready, 1);

    // Latency: visible DEPTH cycles after the accepting cycle, for one cycle.
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("lat_c1_valid", b.out_valid, 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_c2_valid", b.out_valid, 1);
    chk("lat_c2_data", b.out_data, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_c3_valid", b.out_valid, 0);
    chk("lat_occ", occupancy, 0);

    // Streaming 0..15, no bubbles.
    p0 = n_pop;
    rdy_all = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rdy_all &= b.in_ready;
      cyc(1'b1, 8'(i), 1'b1, 1'b0);
    end
    chk("stream_in_ready", rdy_all, 1);
    chk("stream_pops_mid", n_pop - p0, 14);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_pops", n_pop - p0, 16);
    chk("stream_occ", occupancy, 0);

    // Backpressure: capacity is 2*DEPTH.
    v = 1;
    for (int i = 0; i < 6; i++) begin
      ok = b.in_ready;
      cyc(1'b1, 8'(v), 1'b0, 1'b0);
      if (ok) v++;
    end
    acc = v - 1;
    chk("bp_accepted", acc, 2*DEPTH);
    chk("bp_in_ready", b.in_ready, 0);
    chk("bp_occ", occupancy, 4);
    chk("bp_out_data_stall", b.out_data, 8'h01);
    p0 = n_pop;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_drained", n_pop - p0, 4);
    chk("bp_occ_end", occupancy, 0);

    // Flush at occupancy 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("fl_occ3", occupancy, 3);
    b.in_valid = 1'b1; b.out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("fl_in_ready", b.in_ready, 0);
    chk("fl_out_valid", b.out_valid, 0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    chk("fl_occ0", occupancy, 0);
    chk("fl_out_valid_after", b.out_valid, 0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("fl_77_early", b.out_valid, 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl_77_valid", b.out_valid, 1);
    chk("fl_77_data", b.out_data, 8'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random beats with a mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      rst = !(i >= 500 && i < 502);
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rand_sb_empty", q.size(), 0);
    chk("rand_occ_end", occupancy, 0);
    chk("rand_out_valid_end", b.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
